match_filter_sequencer: RTL and testbench



---
 rtl/match_filter_sequencer.sv | 161 ++++++++++++++++
 tb/tb_match_filter_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/match_filter_sequencer.sv
// Control sequencer for the matched filter: load pulse, circular offset, tap sweep, y_valid.
// Optional SAMPLE_DIV_EN replaces sample_strobe with an internal SAMPLE_DIV-clock strobe.
module match_filter_sequencer #(
  parameter int NUM_TAPS   = 128,
  parameter int IDX_W      = 7,
  parameter int DRAIN_CYC  = 2,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample_strobe,
  output logic             mf_ready,
  output logic [IDX_W-1:0] mf_offset,
  output logic [IDX_W-1:0] mf_index,
  output logic [IDX_W-1:0] coeff_addr,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_TAPS - 1);
  localparam logic [IDX_W-1:0] SWEEP_END = IDX_W'(NUM_TAPS - 2);
  localparam int               DRAIN_L   = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;
  localparam logic [IDX_W-1:0] DRAIN_END = IDX_W'(DRAIN_L);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             strobe;
  logic             accept;
  logic             drop;
  logic             in_seq;

`ifdef SAMPLE_DIV_EN
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             unused_strobe;

  assign unused_strobe = sample_strobe;

  // Free-running; the strobe fires on the cycle the counter wraps
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_END) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign strobe = (div_cnt == DIV_END);
`else
  assign strobe = sample_strobe;
`endif

  assign in_seq = (state == S_LOAD)
                | (state == S_SWEEP)
                | (state == S_DRAIN);

  // DONE accepts back-to-back; enable only gates new work
  assign accept = strobe & enable
                & ((state == S_IDLE) | (state == S_DONE));
  assign drop   = strobe & in_seq;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_SWEEP;
        cnt_nxt   = '0;
      end
      S_SWEEP: begin
        if (cnt == SWEEP_END) begin
          cnt_nxt   = '0;
          state_nxt = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_END) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = accept ? S_LOAD : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    mf_ready = 1'b0;
    y_valid  = 1'b0;
    busy     = in_seq;
    mf_index = IDX_LAST;
    unique case (state)
      S_LOAD:  mf_ready = 1'b1;
      S_SWEEP: mf_index = cnt;
      S_DONE:  y_valid  = 1'b1;
      default: ;
    endcase
  end

  assign coeff_addr = mf_index;

  always_ff @(posedge clock) begin
    if (reset) begin
      mf_offset <= '0;
    end else if (accept) begin
      mf_offset <= mf_offset + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hff) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_match_filter_sequencer.sv
// Bench for match_filter_sequencer: table scenarios, corner sequences,
// and random strobes against a time-since-accept reference model.
module tb_match_filter_sequencer;

  localparam int NT   = 128;
  localparam int DC   = 2;
  localparam int SPAN = NT + 1 + DC;
  localparam int FAR  = 100000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sample_strobe = 1'b0;
  logic       mf_ready;
  logic [6:0] mf_offset;
  logic [6:0] mf_index;
  logic [6:0] coeff_addr;
  logic       y_valid;
  logic       busy;
  logic       overrun;
  logic [7:0] drop_count;

  match_filter_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_strobe(sample_strobe),
    .mf_ready     (mf_ready),
    .mf_offset    (mf_offset),
    .mf_index     (mf_index),
    .coeff_addr   (coeff_addr),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: clocks since the last accepted strobe, plus counters
  int m_dist  = FAR;
  int m_off   = 0;
  int m_drops = 0;
  bit m_ov    = 1'b0;

  int n_ready = 0;
  int n_yv    = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit en);
    bit bz;
    int e_idx;
    reset         = rs;
    sample_strobe = st;
    enable        = en;
    @(posedge clock);
    if (rs) begin
      m_dist  = FAR;
      m_off   = 0;
      m_drops = 0;
      m_ov    = 1'b0;
    end else begin
      bz = (m_dist >= 1) && (m_dist < SPAN);
      if (st && bz) begin
        m_ov = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      if (st && !bz && en) begin
        m_dist = 1;
        m_off  = (m_off + 1) % NT;
      end else if (m_dist < FAR) begin
        m_dist++;
      end
    end
    #1;
    e_idx = (m_dist >= 2 && m_dist <= NT) ? m_dist - 2 : NT - 1;
    chk("ready", 32'(mf_ready), 32'(m_dist == 1));
    chk("offset", 32'(mf_offset), 32'(m_off));
    chk("index", 32'(mf_index), 32'(e_idx));
    chk("coeff", 32'(coeff_addr), 32'(e_idx));
    chk("yvalid", 32'(y_valid), 32'(m_dist == SPAN));
    chk("busy", 32'(busy), 32'(m_dist >= 1 && m_dist < SPAN));
    chk("overrun", 32'(overrun), 32'(m_ov));
    chk("drops", 32'(drop_count), 32'(m_drops));
    if (mf_ready === 1'b1) n_ready++;
    if (y_valid === 1'b1) n_yv++;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(0, 0, en);
  endtask

  task automatic do_reset();
    step(1, 0, 1);
    step(1, 0, 1);
    n_ready = 0;
    n_yv    = 0;
  endtask

  typedef struct {
    int gap;
    bit en2;
    int e_acc;
    int e_drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int yv_at;
    tbl[0] = '{gap: 50,  en2: 1'b1, e_acc: 1, e_drop: 1};
    tbl[1] = '{gap: 131, en2: 1'b1, e_acc: 2, e_drop: 0};
    tbl[2] = '{gap: 130, en2: 1'b1, e_acc: 1, e_drop: 1};
    tbl[3] = '{gap: 1,   en2: 1'b1, e_acc: 1, e_drop: 1};
    tbl[4] = '{gap: 132, en2: 1'b1, e_acc: 2, e_drop: 0};
    tbl[5] = '{gap: 200, en2: 1'b0, e_acc: 1, e_drop: 0};
    tbl[6] = '{gap: 60,  en2: 1'b0, e_acc: 1, e_drop: 1};

    // Reset state and single-strobe latency
    do_reset();
    chk("rst_index", 32'(mf_index), 32'd127);
    chk("rst_offset", 32'(mf_offset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle(8, 1);
    step(0, 1, 1);
    chk("t1_ready", 32'(mf_ready), 32'd1);
    chk("t1_offset", 32'(mf_offset), 32'd1);
    yv_at = -1;
    for (int k = 1; k <= 140; k++) begin
      step(0, 0, 1);
      if (k == 1) chk("t1_idx0", 32'(mf_index), 32'd0);
      if (k == 127) chk("t1_idx126", 32'(mf_index), 32'd126);
      if (y_valid === 1'b1 && yv_at < 0) yv_at = k;
    end
    chk("t1_latency", 32'(yv_at), 32'd130);
    chk("t1_ycount", 32'(n_yv), 32'd1);

    // Two-strobe spacing scenarios
    for (int v = 0; v < 7; v++) begin
      do_reset();
      step(0, 1, 1);
      idle(tbl[v].gap - 1, tbl[v].en2);
      step(0, 1, tbl[v].en2);
      idle(300, tbl[v].en2);
      chk($sformatf("vec%0d_acc", v), 32'(n_ready), 32'(tbl[v].e_acc));
      chk($sformatf("vec%0d_yv", v), 32'(n_yv), 32'(tbl[v].e_acc));
      chk($sformatf("vec%0d_drop", v), 32'(drop_count),
          32'(tbl[v].e_drop));
      chk($sformatf("vec%0d_ovr", v), 32'(overrun),
          32'(tbl[v].e_drop > 0));
    end

    // Offset wrap over 128 sweeps
    do_reset();
    for (int s = 0; s < 128; s++) begin
      step(0, 1, 1);
      idle(199, 1);
    end
    chk("wrap_offset", 32'(mf_offset), 32'd0);
    chk("wrap_yv", 32'(n_yv), 32'd128);
    chk("wrap_ovr", 32'(overrun), 32'd0);

    // Reset in the middle of a sweep
    do_reset();
    step(0, 1, 1);
    idle(69, 1);
    step(1, 0, 1);
    chk("mid_index", 32'(mf_index), 32'd127);
    chk("mid_offset", 32'(mf_offset), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    n_yv = 0;
    idle(200, 1);
    chk("mid_noyv", 32'(n_yv), 32'd0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 400; i++) step(0, 1, 1);
    chk("sat_drops", 32'(drop_count), 32'd255);
    chk("sat_ovr", 32'(overrun), 32'd1);

    // Random strobes, enable and occasional reset
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 1999) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
